// File: rtl/alu_mult_sequencer.sv
// Iterative unsigned shift-add multiplier controller driving an external shared ripple adder.
// Optional build macro ALU_MULT_ZERO_SKIP_EN bypasses the adder for zero multiplier bits.
module alu_mult_sequencer #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic                 alu_sub,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_carryout
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   mcand, mcand_n;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic               cbit, cbit_n;
  logic [BW-1:0]      bitcnt, bitcnt_n;
  logic [SW-1:0]      settlecnt, settlecnt_n;

  assign alu_a   = acc[2*WIDTH-1:WIDTH];
  assign alu_sub = 1'b0;

  // State and datapath registers; alu_b is precomputed from the next lo[0]/mcand.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      mcand     <= '0;
      acc       <= '0;
      cbit      <= 1'b0;
      bitcnt    <= '0;
      settlecnt <= '0;
      product   <= '0;
      done      <= 1'b0;
      ready     <= 1'b1;
      alu_b     <= '0;
    end else begin
      state     <= state_n;
      mcand     <= mcand_n;
      acc       <= acc_n;
      cbit      <= cbit_n;
      bitcnt    <= bitcnt_n;
      settlecnt <= settlecnt_n;
      ready     <= (state_n == S_IDLE);
      done      <= (state == S_DONE);
      alu_b     <= acc_n[0] ? mcand_n : '0;
      if (state == S_DONE) begin
        product <= acc;
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_n     = state;
    mcand_n     = mcand;
    acc_n       = acc;
    cbit_n      = cbit;
    bitcnt_n    = bitcnt;
    settlecnt_n = settlecnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          mcand_n = multiplicand;
          acc_n   = {WIDTH'(0), multiplier};
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        bitcnt_n    = '0;
        settlecnt_n = '0;
        cbit_n      = 1'b0;
`ifdef ALU_MULT_ZERO_SKIP_EN
        state_n     = acc[0] ? S_EVAL : S_SHIFT;
`else
        state_n     = S_EVAL;
`endif
      end
      S_EVAL: begin
        if (settlecnt == SW'(SETTLE_CYCLES - 1)) begin
          acc_n[2*WIDTH-1:WIDTH] = alu_result;
          cbit_n                 = alu_carryout;
          state_n                = S_SHIFT;
        end else begin
          settlecnt_n = settlecnt + SW'(1);
        end
      end
      S_SHIFT: begin
        // The captured carry becomes the new top bit so no product bit is lost.
        acc_n  = {cbit, acc[2*WIDTH-1:1]};
        cbit_n = 1'b0;
        if (bitcnt == BW'(WIDTH - 1)) begin
          state_n = S_DONE;
        end else begin
          bitcnt_n    = bitcnt + BW'(1);
          settlecnt_n = '0;
`ifdef ALU_MULT_ZERO_SKIP_EN
          state_n     = acc_n[0] ? S_EVAL : S_SHIFT;
`else
          state_n     = S_EVAL;
`endif
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Self-checking bench for alu_mult_sequencer with a behavioural ripple adder model.
module tb_alu_mult_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        ready;
  logic        done;
  logic [63:0] product;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_sub;
  logic [31:0] alu_result;
  logic        alu_carryout;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb[$];

  alu_mult_sequencer #(.WIDTH(32), .SETTLE_CYCLES(2)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .ready(ready),
    .done(done),
    .product(product),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_sub(alu_sub),
    .alu_result(alu_result),
    .alu_carryout(alu_carryout)
  );

  // External shared adder (add mode only).
  assign {alu_carryout, alu_result} = 33'(alu_a) + 33'(alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) check("alu_sub", 64'(alu_sub), 64'd0);
  end

  function automatic int exp_lat(input logic [31:0] b);
`ifdef ALU_MULT_ZERO_SKIP_EN
    int n;
    n = $countones(b);
    return 2 + n * 3 + (32 - n);
`else
    return 98 + 0 * int'(b[0]);
`endif
  endfunction

  // Waits for done; pops the scoreboard and compares product. Optionally disturbs inputs mid-run.
  task automatic wait_done(input bit disturb, output int lat, output bit ready_bad);
    bit got;
    logic [63:0] exp;
    got = 0;
    lat = 0;
    ready_bad = 0;
    while (!got && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      if (disturb) begin
        if (lat == 10 || lat == 50) begin
          start = 1'b1;
          multiplicand = $urandom;
          multiplier = $urandom;
        end else begin
          start = 1'b0;
        end
      end
      if (done) got = 1;
      else if (ready) ready_bad = 1;
    end
    if (!got) begin
      check("done_timeout", 64'(lat), 64'd0);
    end else if (sb.size() == 0) begin
      check("unexpected_done", 64'd1, 64'd0);
    end else begin
      exp = sb.pop_front();
      check("product", product, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                        input bit disturb);
    int lat;
    bit rb;
    logic [63:0] held;
    @(negedge clk);
    multiplicand = a;
    multiplier = b;
    start = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    multiplicand = ~a;
    multiplier = ~b;
    wait_done(disturb, lat, rb);
    check("latency", 64'(lat), 64'(exp_lat(b)));
    check("ready_low_during_op", 64'(rb), 64'd0);
    held = product;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("done_one_pulse", 64'(done), 64'd0);
    check("ready_after_done", 64'(ready), 64'd1);
    check("product_held", product, held);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    bit rb;
    int pulses;

    vecs[0] = '{32'd3, 32'd5, 64'h0F};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[2] = '{32'd0, 32'd12345, 64'd0};
    vecs[3] = '{32'd12345, 32'd0, 64'd0};
    vecs[4] = '{32'd1, 32'd1, 64'd1};
    vecs[5] = '{32'h80000000, 32'd2, 64'h100000000};
    vecs[6] = '{32'h80000001, 32'd3, 64'h180000003};
    vecs[7] = '{32'd6, 32'd1, 64'd6};

    reset = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", product, 64'd0);
    check("reset_alu_a", 64'(alu_a), 64'd0);
    check("reset_alu_b", 64'(alu_b), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_ready", 64'(ready), 64'd1);
    check("idle_done", 64'(done), 64'd0);
    check("idle_product", product, 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, 1'b0);
    end

    // Start pulses and operand changes while busy must be ignored.
    run_op(32'd11, 32'd13, 64'd143, 1'b1);

    // Reset mid-operation aborts with no done pulse.
    @(negedge clk);
    multiplicand = 32'd7;
    multiplier = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", product, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    run_op(32'd7, 32'd9, 64'd63, 1'b0);

    // start held high: next op begins on the IDLE cycle that carries done.
    @(negedge clk);
    multiplicand = 32'd2;
    multiplier = 32'd3;
    start = 1'b1;
    sb.push_back(64'd6);
    sb.push_back(64'd20);
    @(posedge clk);
    #1;
    multiplicand = 32'd4;
    multiplier = 32'd5;
    wait_done(1'b0, lat, rb);
    check("held_lat1", 64'(lat), 64'(exp_lat(32'd3)));
    wait_done(1'b0, lat, rb);
    start = 1'b0;
    check("held_lat2", 64'(lat), 64'(exp_lat(32'd5) + 1));
    check("sb_empty", 64'(sb.size()), 64'd0);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
